// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO write-side arbiter.
// The beat counter width is derived from the burst length by beat_width().
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CNT_W     = 6;
  localparam int DEF_BURST_MAX = 4;
  localparam int DEF_HIGH_WM   = 28;

  // grant_id is 3 bits wide, which covers up to 8 requesters.
  localparam int ID_W = 3;

  // The counter must be able to hold the value BURST_MAX itself.
  function automatic int beat_width(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first set request bit
// found by searching upward from last_grant+1 and wrapping to index 0.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  logic found;

  // NOTE: every variable is given a default before the loops so no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    any_req = |req;
    // Indices above the last winner take precedence over the wrapped ones.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (ID_W'(i) > last_grant)) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (ID_W'(i) <= last_grant)) begin
        found  = 1'b1;
        winner = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that grants one FIFO write port to several producers
// for bounded bursts, throttled by FIFO occupancy and stalled on full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int BURST_MAX = DEF_BURST_MAX,
  parameter int HIGH_WM   = DEF_HIGH_WM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data,
  input  logic                      fifo_full,
  input  logic [CNT_W-1:0]          fifo_counter,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id
);

  localparam int BW = beat_width(BURST_MAX);

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic [BW-1:0]     beat_cnt;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              burst_done;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any_req    (any_req)
  );

  // Route the granted requester to the FIFO; nothing is driven while IDLE.
  always_comb begin
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    sel_data   = '0;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
    if (state == BURST) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_id == ID_W'(i)) req_ready[i] = !fifo_full;
      end
      fifo_wr_en = sel_valid && !fifo_full;
      fifo_data  = sel_data;
    end
  end

  // A full FIFO neither transfers nor ends the burst.
  assign burst_done = (fifo_wr_en && (sel_last || (beat_cnt == BW'(BURST_MAX - 1))))
                    || (!sel_valid && !fifo_full);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      beat_cnt    <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req && (fifo_counter < CNT_W'(HIGH_WM))) begin
            state       <= BURST;
            grant_valid <= 1'b1;
            grant_id    <= winner;
            last_grant  <= winner;
            beat_cnt    <= '0;
          end
        end
        BURST: begin
          if (fifo_wr_en) beat_cnt <= beat_cnt + BW'(1);
          if (burst_done) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one elastic 8-bit FIFO (random_pntr_fifo) between several producers. It grants the FIFO write port to one requester at a time for a bounded burst and drives the FIFO's write enable and write data directly. It throttles new grants using the FIFO occupancy counter and stalls an active burst on buf_full. It sits between the producer blocks and the FIFO instance; the read side is untouched.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, data width; matches FIFO data_in
- CNT_W, 6, width of FIFO occupancy counter
- BURST_MAX, 4, maximum words per grant (1..15)
- HIGH_WM, 28, no new grant when fifo_counter >= HIGH_WM
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- req_valid  input  NUM_REQ  requester i has a word
- req_data  input  NUM_REQ*DATA_W  word of requester i at bits [i*DATA_W +: DATA_W]
- req_last  input  NUM_REQ  word is the last of requester i's burst
- req_ready  output  NUM_REQ  word of requester i accepted this cycle when valid
- fifo_wr_en  output  1  to FIFO wr_en
- fifo_data  output  DATA_W  to FIFO data_in
- fifo_full  input  1  from FIFO buf_full
- fifo_counter  input  CNT_W  from FIFO counter
- grant_valid  output  1  a burst is in progress
- grant_id  output  3  index of the granted requester; 0 when idle

## Operation
- FSM states: IDLE, BURST. Reset state is IDLE.
- IDLE: when any req_valid=1 and fifo_counter < HIGH_WM, select the first requester with valid=1, searching from last_grant+1 with wrap. Register grant_id, clear beat_cnt, set last_grant to the winner, go to BURST.
- BURST, granted requester g:
  - req_ready[g] = !fifo_full; all other ready bits are 0.
  - Transfer = req_valid[g] & req_ready[g].
  - fifo_wr_en = transfer; fifo_data = req_data[g], combinational.
  - beat_cnt increments on each transfer.
- BURST exits to IDLE at the next edge when any of these holds:
  - a transfer with req_last[g]=1;
  - a transfer that brings beat_cnt to BURST_MAX;
  - req_valid[g]=0 while fifo_full=0 (requester went idle).
- A cycle with fifo_full=1 holds the burst with no transfer and no exit. HIGH_WM does not stop a burst already in progress.
- IDLE has no ready and no writes. This gives one dead cycle between consecutive bursts.
- fifo_wr_en is never 1 while fifo_full=1. This is required: it prevents FIFO overflow.

## Timing
- Reset values: state=IDLE, grant_valid=0, grant_id=0, req_ready=0, fifo_wr_en=0, fifo_data=0, beat_cnt=0, last_grant=NUM_REQ-1, so requester 0 wins first.
- Reset asserted mid-burst forces all of the above immediately, with no clock needed. The partial burst is abandoned; the FIFO keeps any words already written.
- Latency: req_valid rising in cycle N (IDLE, below watermark) gives grant_valid=1 and the first transfer in cycle N+1.
- Simultaneous requests are resolved by round-robin only; there is no fixed priority.
- A requester that keeps valid high is re-granted only after every other valid requester has had a turn.
- fifo_counter and fifo_full are sampled combinationally in the same cycle; no extra pipelining.

## Structure
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - default constants DATA_W=8, CNT_W=6, BURST_MAX=4, HIGH_WM=28;
  - the beat counter width, clog2(BURST_MAX+1).
- Sub-module rr_picker: combinational. Inputs are the request vector and last_grant; outputs are winner index and any_req. It is instantiated once.
- The FSM, beat counter and output muxing live in fifo_wr_arbiter.

## Test plan
- Reset, then req0 valid with words 0x00..0x03 and last on 0x03: fifo_wr_en is high for 4 cycles starting 1 cycle after valid, with fifo_data 0x00..0x03; grant_id=0; grant_valid drops after the 4th word.
- All 4 requesters continuously valid, never last, BURST_MAX=4: grant order 0,1,2,3,0. Each grant writes exactly 4 words, with one idle cycle between grants.
- Burst active and fifo_full asserted for 3 cycles: fifo_wr_en=0 and req_ready=0 during those cycles, grant_id unchanged; the burst resumes with no word lost or duplicated.
- fifo_counter=28 with req1 valid in IDLE: no grant. Drop counter to 27: grant to req1 on the next cycle.
- rst driven low in the middle of req2's burst, after its 2nd word: all outputs reset asynchronously. After release, req2 still valid: it is granted; a simultaneous req0 wins first because last_grant was reset to NUM_REQ-1.
- req3 deasserts valid mid-burst with fifo not full: FSM returns to IDLE the next cycle, and waiting req0 is then granted.
